// File: rtl/common.sv
// Shared coherence types: MSI line state (same encoding as the arbiter's BLOCK_STATE),
// controller FSM states and bus request kinds.
package common;

    typedef enum logic [1:0] {
        BLK_M = 2'b00,
        BLK_S = 2'b01,
        BLK_I = 2'b10
    } blk_state_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GNT,
        FILL,
        DONE
    } coh_fsm_t;

    typedef enum logic [1:0] {
        RMISS,
        WMISS,
        UPG
    } req_kind_t;

endpackage

// File: rtl/coh_tag_array.sv
// Direct-mapped tag/state store with a CPU read port, a snoop read port and a write
// port where a refill on an index overrides a same-cycle snoop update to that index.
module coh_tag_array
    import common::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned IDX_W     = $clog2(NUM_LINES),
    parameter int unsigned TAG_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_cpu_idx,
    output logic [TAG_W-1:0] o_cpu_tag,
    output blk_state_t       o_cpu_state,
    input  logic [IDX_W-1:0] i_snp_idx,
    output logic [TAG_W-1:0] o_snp_tag,
    output blk_state_t       o_snp_state,
    input  logic             i_fill_we,
    input  logic [IDX_W-1:0] i_fill_idx,
    input  logic [TAG_W-1:0] i_fill_tag,
    input  blk_state_t       i_fill_state,
    input  logic             i_snp_we,
    input  blk_state_t       i_snp_state
);

    logic [TAG_W-1:0] r_tag   [NUM_LINES];
    blk_state_t       r_state [NUM_LINES];
    logic             w_snp_blocked;

    // The line is being refilled, so a snoop result for it is stale.
    assign w_snp_blocked = i_fill_we && (i_fill_idx == i_snp_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_tag[i]   <= '0;
                r_state[i] <= BLK_I;
            end
        end else begin
            if (i_snp_we && !w_snp_blocked) begin
                r_state[i_snp_idx] <= i_snp_state;
            end
            if (i_fill_we) begin
                r_tag[i_fill_idx]   <= i_fill_tag;
                r_state[i_fill_idx] <= i_fill_state;
            end
        end
    end

    assign o_cpu_tag   = r_tag[i_cpu_idx];
    assign o_cpu_state = r_state[i_cpu_idx];
    assign o_snp_tag   = r_tag[i_snp_idx];
    assign o_snp_state = r_state[i_snp_idx];

endmodule

// File: rtl/coh_ctrl.sv
// Per-core MSI coherence controller: turns d-cache misses/upgrades into snoopy-bus
// requests, stalls the CPU until the granted transaction completes, and answers peer snoops.
module coh_ctrl
    import common::*;
#(
    parameter int unsigned NUM_LINES = 8,
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned FILL_LAT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_stall,
    output logic              read_miss,
    output logic              write_miss,
    output logic              invalidate,
    output blk_state_t        block_state,
    output logic [ADDR_W-1:0] BICO,
    input  logic              grant,
    input  logic              datasel,
    input  logic              search,
    input  logic              inv_from_other,
    input  logic [ADDR_W-1:0] BOCI,
    output logic              search_found,
    output logic              evict_wb,
    output logic [ADDR_W-1:0] evict_addr
);

    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam int unsigned CNT_W = $clog2(FILL_LAT) + 1;

    coh_fsm_t          r_fsm, w_fsm_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    req_kind_t         r_kind, w_kind_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_search_found;

    logic [ADDR_W-1:0] w_lk_addr;
    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic [TAG_W-1:0]  w_arr_tag;
    blk_state_t        w_arr_state;
    blk_state_t        w_lk_state;

    logic              w_acc;
    logic              w_hit;
    req_kind_t         w_acc_kind;
    req_kind_t         w_req_kind;
    logic              w_evict;

    logic [IDX_W-1:0]  w_snp_idx;
    logic [TAG_W-1:0]  w_snp_tag;
    logic [TAG_W-1:0]  w_snp_arr_tag;
    blk_state_t        w_snp_arr_state;
    logic              w_snp_match;
    logic              w_snp_we;
    blk_state_t        w_snp_state;

    logic              w_fill_we;
    blk_state_t        w_fill_state;

    // While a transaction is open the CPU port tracks the captured address so the
    // request kind follows live line state.
    assign w_lk_addr  = (r_fsm == IDLE) ? cpu_addr : r_addr;
    assign w_lk_idx   = w_lk_addr[IDX_W-1:0];
    assign w_lk_tag   = w_lk_addr[ADDR_W-1:IDX_W];
    assign w_lk_state = (w_arr_tag == w_lk_tag) ? w_arr_state : BLK_I;

    assign w_acc      = cpu_rd | cpu_wr;
    assign w_hit      = cpu_wr ? (w_lk_state == BLK_M) : (w_lk_state != BLK_I);
    assign w_acc_kind = cpu_wr ? ((w_lk_state == BLK_S) ? UPG : WMISS) : RMISS;
    assign w_req_kind = (r_kind == RMISS) ? RMISS : ((w_lk_state == BLK_S) ? UPG : WMISS);

    assign w_evict      = (w_arr_state == BLK_M) && (w_arr_tag != r_addr[ADDR_W-1:IDX_W]);
    assign w_fill_state = (r_kind == RMISS) ? BLK_S : BLK_M;

    assign w_snp_idx   = BOCI[IDX_W-1:0];
    assign w_snp_tag   = BOCI[ADDR_W-1:IDX_W];
    assign w_snp_match = (w_snp_arr_tag == w_snp_tag) && (w_snp_arr_state != BLK_I);

    always_comb begin
        w_snp_we    = 1'b0;
        w_snp_state = w_snp_arr_state;
        if (inv_from_other && w_snp_match) begin
            w_snp_we    = 1'b1;
            w_snp_state = BLK_I;
        end else if (search && w_snp_match && (w_snp_arr_state == BLK_M)) begin
            w_snp_we    = 1'b1;
            w_snp_state = BLK_S;
        end
    end

    coh_tag_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_tag_array (
        .clk          (clk),
        .rst          (rst),
        .i_cpu_idx    (w_lk_idx),
        .o_cpu_tag    (w_arr_tag),
        .o_cpu_state  (w_arr_state),
        .i_snp_idx    (w_snp_idx),
        .o_snp_tag    (w_snp_arr_tag),
        .o_snp_state  (w_snp_arr_state),
        .i_fill_we    (w_fill_we),
        .i_fill_idx   (r_addr[IDX_W-1:0]),
        .i_fill_tag   (r_addr[ADDR_W-1:IDX_W]),
        .i_fill_state (w_fill_state),
        .i_snp_we     (w_snp_we),
        .i_snp_state  (w_snp_state)
    );

    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_addr_nxt = r_addr;
        w_kind_nxt = r_kind;
        w_cnt_nxt  = r_cnt;
        cpu_stall  = 1'b0;
        read_miss  = 1'b0;
        write_miss = 1'b0;
        invalidate = 1'b0;
        w_fill_we  = 1'b0;
        evict_wb   = 1'b0;
        unique case (r_fsm)
            IDLE: begin
                if (w_acc && !w_hit) begin
                    cpu_stall  = 1'b1;
                    w_addr_nxt = cpu_addr;
                    w_kind_nxt = w_acc_kind;
                    w_fsm_nxt  = REQ;
                end
            end
            REQ: begin
                cpu_stall  = 1'b1;
                w_kind_nxt = w_req_kind;
                case (w_req_kind)
                    RMISS:   read_miss  = 1'b1;
                    WMISS:   write_miss = 1'b1;
                    default: invalidate = 1'b1;
                endcase
                if (grant) begin
                    w_fsm_nxt = GNT;
                end
            end
            GNT: begin
                cpu_stall = 1'b1;
                if (r_kind == UPG) begin
                    w_fsm_nxt = DONE;
                end else begin
                    w_cnt_nxt = datasel ? '0 : CNT_W'(FILL_LAT - 1);
                    w_fsm_nxt = FILL;
                end
            end
            FILL: begin
                cpu_stall = 1'b1;
                if (r_cnt == '0) begin
                    w_fsm_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            DONE: begin
                w_fill_we = 1'b1;
                evict_wb  = w_evict;
                w_fsm_nxt = IDLE;
            end
            default: begin
                w_fsm_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm          <= IDLE;
            r_addr         <= '0;
            r_kind         <= RMISS;
            r_cnt          <= '0;
            r_search_found <= 1'b0;
        end else begin
            r_fsm          <= w_fsm_nxt;
            r_addr         <= w_addr_nxt;
            r_kind         <= w_kind_nxt;
            r_cnt          <= w_cnt_nxt;
            r_search_found <= search && w_snp_match;
        end
    end

    assign block_state  = w_lk_state;
    assign BICO         = r_addr;
    assign search_found = r_search_found;
    assign evict_addr   = evict_wb ? {w_arr_tag, r_addr[IDX_W-1:0]} : '0;

endmodule

// File: tb/tb_coh_ctrl.sv
// Directed and randomized checks of coh_ctrl against a transaction-level MSI cache model.
module tb_coh_ctrl;

    localparam logic [1:0] ST_M = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_I = 2'b10;
    localparam int K_R    = 0;
    localparam int K_W    = 1;
    localparam int K_U    = 2;
    localparam int K_NONE = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd, cpu_wr;
    logic [10:0] cpu_addr;
    logic        cpu_stall, read_miss, write_miss, invalidate;
    logic [1:0]  block_state;
    logic [10:0] BICO;
    logic        grant, datasel, search, inv_from_other;
    logic [10:0] BOCI;
    logic        search_found, evict_wb;
    logic [10:0] evict_addr;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_tag [8];
    logic [1:0] m_st  [8];

    coh_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_rd         (cpu_rd),
        .cpu_wr         (cpu_wr),
        .cpu_addr       (cpu_addr),
        .cpu_stall      (cpu_stall),
        .read_miss      (read_miss),
        .write_miss     (write_miss),
        .invalidate     (invalidate),
        .block_state    (block_state),
        .BICO           (BICO),
        .grant          (grant),
        .datasel        (datasel),
        .search         (search),
        .inv_from_other (inv_from_other),
        .BOCI           (BOCI),
        .search_found   (search_found),
        .evict_wb       (evict_wb),
        .evict_addr     (evict_addr)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reqs(input string tag, input int k);
        chk({tag, "_rm"}, read_miss, k == K_R);
        chk({tag, "_wm"}, write_miss, k == K_W);
        chk({tag, "_inv"}, invalidate, k == K_U);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) begin
            m_tag[i] = '0;
            m_st[i]  = ST_I;
        end
    endfunction

    function automatic logic [1:0] m_state(input logic [10:0] a);
        return (m_tag[a[2:0]] == a[10:3]) ? m_st[a[2:0]] : ST_I;
    endfunction

    // Applies one snoop to the model and returns whether a peer probe would find the line.
    function automatic bit m_snoop(input bit s, input bit inv, input logic [10:0] a);
        logic [1:0] st;
        bit         f;
        st = m_state(a);
        f  = s && (st != ST_I);
        if (inv && st != ST_I) m_st[a[2:0]] = ST_I;
        else if (s && st == ST_M) m_st[a[2:0]] = ST_S;
        return f;
    endfunction

    task automatic do_snoop(input bit s, input bit inv, input logic [10:0] a);
        bit exp_f;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        search = s;
        inv_from_other = inv;
        BOCI = a;
        exp_f = m_snoop(s, inv, a);
        cyc();
        search = 1'b0;
        inv_from_other = 1'b0;
        #1;
        chk("snp_found", search_found, exp_f);
        cpu_addr = a;
        #1;
        chk("snp_bstate", block_state, m_state(a));
        cyc();
        #1;
        chk("snp_found_clr", search_found, 1'b0);
    endtask

    task automatic do_access(input bit wr, input logic [10:0] a, input bit ds, input int gdly,
                             input bit inv_mid);
        logic [1:0]  st0;
        logic [10:0] ev_addr;
        logic [10:0] exp_ev_addr;
        int          kind;
        int          k;
        int          ev_cnt;
        int          exp_lat;
        bit          exp_ev;
        bit          done;
        bit          fnd;
        cpu_addr = a;
        cpu_wr   = wr;
        cpu_rd   = !wr || ($urandom_range(0, 1) == 1);
        datasel  = ds;
        #1;
        st0 = m_state(a);
        chk("acc_bstate", block_state, st0);
        if (wr ? (st0 == ST_M) : (st0 != ST_I)) begin
            chk("hit_stall", cpu_stall, 1'b0);
            chk_reqs("hit_req", K_NONE);
            cyc();
            cpu_rd = 1'b0;
            cpu_wr = 1'b0;
            return;
        end
        chk("miss_stall", cpu_stall, 1'b1);
        cyc();
        kind = K_R;
        for (int i = 0; i <= gdly; i++) begin
            #1;
            kind = !wr ? K_R : ((m_state(a) == ST_S) ? K_U : K_W);
            chk_reqs("req", kind);
            chk("req_bico", BICO, a);
            chk("req_stall", cpu_stall, 1'b1);
            chk("req_bstate", block_state, m_state(a));
            if (i == gdly) grant = 1'b1;
            if (inv_mid && i == 0 && gdly > 0) begin
                inv_from_other = 1'b1;
                BOCI = a;
                fnd = m_snoop(1'b0, 1'b1, a);
            end
            cyc();
            grant = 1'b0;
            inv_from_other = 1'b0;
        end
        exp_lat     = (kind == K_U) ? 2 : (ds ? 3 : 6);
        exp_ev      = (m_st[a[2:0]] == ST_M) && (m_tag[a[2:0]] != a[10:3]);
        exp_ev_addr = {m_tag[a[2:0]], a[2:0]};
        ev_cnt  = 0;
        ev_addr = '0;
        k       = 1;
        done    = 1'b0;
        while (!done && k <= 12) begin
            #1;
            if (k == 1) chk_reqs("gnt_req", K_NONE);
            if (evict_wb) begin
                ev_cnt++;
                ev_addr = evict_addr;
            end
            if (!cpu_stall) done = 1'b1;
            else begin
                cyc();
                k++;
            end
        end
        chk("latency", k, exp_lat);
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cyc();
        #1;
        if (evict_wb) ev_cnt++;
        chk("evict_cnt", ev_cnt, exp_ev);
        if (exp_ev) chk("evict_addr", ev_addr, exp_ev_addr);
        m_tag[a[2:0]] = a[10:3];
        m_st[a[2:0]]  = wr ? ST_M : ST_S;
        chk("fill_bstate", block_state, m_state(a));
    endtask

    initial begin
        logic [10:0] ra;
        rst = 1'b1;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        cpu_addr = '0;
        grant = 1'b0;
        datasel = 1'b0;
        search = 1'b0;
        inv_from_other = 1'b0;
        BOCI = '0;
        m_reset();
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_stall", cpu_stall, 1'b0);
        chk_reqs("rst", K_NONE);
        chk("rst_bstate", block_state, ST_I);
        chk("rst_bico", BICO, 11'h0);
        chk("rst_evict", evict_wb, 1'b0);
        chk("rst_evaddr", evict_addr, 11'h0);
        chk("rst_found", search_found, 1'b0);

        do_access(1'b0, 11'h123, 1'b0, 1, 1'b0);   // read miss, dmem fill
        do_snoop(1'b0, 1'b1, 11'h123);
        do_access(1'b0, 11'h123, 1'b1, 0, 1'b0);   // read miss, peer fill
        do_access(1'b1, 11'h123, 1'b0, 1, 1'b0);   // S->M upgrade
        do_access(1'b1, 11'h040, 1'b0, 0, 1'b0);
        do_snoop(1'b1, 1'b0, 11'h040);             // M -> S, found
        do_snoop(1'b1, 1'b0, 11'h048);             // same index, other tag
        do_snoop(1'b1, 1'b0, 11'h123);             // 0x123 back to S
        do_access(1'b1, 11'h123, 1'b0, 2, 1'b1);   // upgrade turned into write miss
        do_access(1'b1, 11'h005, 1'b1, 0, 1'b0);
        do_access(1'b0, 11'h00D, 1'b0, 0, 1'b0);   // evicts M line 0x005
        do_access(1'b0, 11'h00D, 1'b0, 0, 1'b0);   // now a hit
        do_snoop(1'b1, 1'b1, 11'h00D);             // search+inv together

        // Reset in the middle of a request.
        cpu_addr = 11'h2AB;
        cpu_wr = 1'b1;
        #1;
        chk("mr_stall", cpu_stall, 1'b1);
        cyc();
        #1;
        chk("mr_wm", write_miss, 1'b1);
        rst = 1'b1;
        cpu_wr = 1'b0;
        cyc();
        #1;
        chk_reqs("mr_after", K_NONE);
        chk("mr_stall_after", cpu_stall, 1'b0);
        chk("mr_bico", BICO, 11'h0);
        rst = 1'b0;
        m_reset();
        cpu_addr = 11'h040;
        #1;
        chk("mr_bstate", block_state, ST_I);
        cyc();

        for (int n = 0; n < 200; n++) begin
            ra = {3'b000, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
            if ($urandom_range(0, 9) < 7) begin
                do_access(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
            end else begin
                do_snoop(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra);
            end
            if ($urandom_range(0, 3) == 0) cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/coh_ctrl.md
Name: coh_ctrl

Overview:
- Per-CPU MSI coherence controller. One instance per core, placed directly upstream of the shared snoopy bus arbiter.
- Turns d-cache read and write accesses into read_miss, write_miss and invalidate bus requests, and presents BICO and block_state to the arbiter.
- Answers peer snoops (search, inv_from_other) against its own tag/state array.
- Stalls the CPU until a granted transaction completes.

Parameters:
- NUM_LINES, 8, direct-mapped lines (power of 2); one word per block.
- ADDR_W, 11, full word address width; tag = ADDR_W-log2(NUM_LINES) bits.
- FILL_LAT, 4, cycles to receive a block from dmem; a peer-sourced fill takes 1 cycle.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_rd  in  1  load access this cycle
- cpu_wr  in  1  store access this cycle
- cpu_addr  in  ADDR_W  access address
- cpu_stall  out  1  hold pipeline
- read_miss  out  1  bus request
- write_miss  out  1  bus request
- invalidate  out  1  bus request (S->M upgrade)
- block_state  out  2  state of the line at cpu_addr: M=00, S=01, I=10; a tag mismatch reports I
- BICO  out  ADDR_W  request address
- grant  in  1  bus grant for this core
- datasel  in  1  1 = fill sourced from peer, 0 = from dmem
- search  in  1  peer snoop-read probe
- inv_from_other  in  1  peer invalidation
- BOCI  in  ADDR_W  snoop address
- search_found  out  1  probe hit a valid (M/S) line
- evict_wb  out  1  one-cycle pulse: M line being replaced
- evict_addr  out  ADDR_W  address of evicted M line

Behaviour:
- Reset (rst high at posedge): all lines go to I with tags 0 and the FSM goes to IDLE. All outputs are 0 except block_state=I, BICO=0 and evict_addr=0. Reset mid-transaction abandons the transaction; the bus sees the requests drop on the next cycle.

Hit classification (combinational, on cpu_addr):
- Read hit: the line is M or S.
- Write hit: the line is M.
- Write to S: needs UPG (upgrade).
- Any other access: needs RMISS (read) or WMISS (write).
- A hit completes in 0 cycles, cpu_stall=0.
- A store hit to M updates nothing in the state array.

FSM states: IDLE, REQ, GNT, FILL, DONE.
- IDLE, access with a miss or upgrade:
  - cpu_stall=1 combinationally.
  - Capture the address and kind.
  - Go to REQ.
- REQ:
  - Drive exactly one of read_miss, write_miss or invalidate, with BICO = the captured address.
  - The kind is re-evaluated every cycle from live state: if a snoop invalidation turns an S line being upgraded into I, the request switches from invalidate to write_miss on the same cycle.
  - On grant=1: go to GNT and deassert all requests next cycle.
- GNT (the arbiter's op cycle):
  - Sample datasel into src.
  - An UPG goes directly to DONE.
  - Otherwise go to FILL, loading the counter with FILL_LAT-1 (dmem) or 0 (peer).
- FILL:
  - Counter decrements; at 0, go to DONE.
  - No wrap: the counter is width clog2(FILL_LAT)+1 and saturates at 0.
- DONE:
  - Write the tag and set state: S for RMISS, M for WMISS or UPG.
  - If the replaced line was M with a different tag, pulse evict_wb with evict_addr = {old tag, index}.
  - Deassert cpu_stall this cycle.
  - Go to IDLE.

Snoop path (independent of the FSM, every cycle):
- search_found registered: equals search && tag(BOCI) matches && state != I, 1 cycle after search.
- A search hit on M downgrades the line to S (registered).
- inv_from_other with a tag match forces the line to I at the next edge.

Simultaneous events:
- Snoop update and DONE write on the same index: DONE wins; the snoop is ignored because the line is being refilled.
- search and inv_from_other together on the same line: the line goes to I, and search_found still reflects the pre-edge state.
- cpu_rd and cpu_wr both high: treated as a write.

Decomposition:
- Add to the shared package `common`:
  - blk_state_t enum (BLK_M=2'b00, BLK_S=2'b01, BLK_I=2'b10) shared with the arbiter's BLOCK_STATE constants.
  - coh_fsm_t enum (IDLE, REQ, GNT, FILL, DONE).
  - The req_kind_t enum (RMISS, WMISS, UPG).
- Sub-module coh_tag_array:
  - Tag/state flops.
  - One combinational CPU lookup port and one snoop lookup port.
  - One prioritized write port: fill beats snoop.

Test Plan:
- Reset, then cpu_rd to 0x123 → next cycle read_miss=1, BICO=0x123, cpu_stall=1. Grant on cycle 3 with datasel=0 → stall released 1+4+1 cycles after grant, and the line is S.
- Same read with datasel=1 in GNT → FILL lasts 1 cycle and stall drops 3 cycles after grant.
- Line 0x123 in S, cpu_wr 0x123 → invalidate=1, block_state=01. After grant, line is M with no fill cycles.
- Line 0x040 in M, search=1 with BOCI=0x040 → search_found=1 next cycle and the line becomes S. Repeat with BOCI=0x048 (same index, different tag) → search_found=0.
- Upgrade pending in REQ on 0x123 and inv_from_other on BOCI=0x123 → next cycle invalidate=0, write_miss=1, block_state=10.
- Line 0x005 in M, cpu_rd to 0x00D → fill completes with evict_wb pulsing exactly 1 cycle and evict_addr=0x005, and the new line is S.
